// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART character transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_t;

  localparam int unsigned UART_DEFAULT_CLKS_PER_BIT = 868;
  localparam int unsigned UART_DEFAULT_FIFO_DEPTH   = 16;

endpackage

// File: rtl/char_fifo.sv
// Single-clock character FIFO. Occupancy counter drives full/empty; pointers
// wrap modulo Depth (power of two). A push while full is taken only together
// with a pop in the same cycle.
module char_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [Width-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [Width-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  // Qualify requests against current occupancy.
  always_comb begin
    empty_o = (count_q == '0);
    full_o  = (count_q == (PtrW + 1)'(Depth));
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);
    rdata_o = mem_q[rptr_q];
    count_o = count_q;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

  // Storage needs no reset; contents are only visible through valid pointers.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_char_tx.sv
// Buffered 8N1 serial transmitter for the simulated-UART character stream.
// Optional feature macro: UART_TX_PARITY_EN inserts an even-parity bit (8E1).
// tx and busy are registered from the current FSM state, so the line lags the
// FSM by one cycle: a byte written at edge E is popped at E+1 and tx drops
// after E+2.
module uart_char_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  parameter int unsigned FIFO_DEPTH   = UART_DEFAULT_FIFO_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  char_in,
  input  logic                        char_valid,
  input  logic                        ovf_clr,
  output logic                        tx,
  output logic                        busy,
  output logic                        fifo_full,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  output logic [7:0]                  drop_cnt
);

  localparam int unsigned          BaudW    = $clog2(CLKS_PER_BIT);
  localparam logic [BaudW-1:0]     BaudLast = BaudW'(CLKS_PER_BIT - 1);

  tx_state_t        state_q;
  logic [BaudW-1:0] baud_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shreg_q;
  logic             tx_q, busy_q;
  logic             overflow_q;
  logic [7:0]       drop_cnt_q;
`ifdef UART_TX_PARITY_EN
  logic             par_q;
`endif

  logic       fifo_empty;
  logic [7:0] fifo_rdata;
  logic       baud_last, pop, push_ok, drop;

  // Pop only when idle or on the final stop-bit cycle; a full FIFO still
  // accepts a push when a pop happens alongside it.
  always_comb begin
    baud_last = (baud_q == BaudLast);
    pop       = !fifo_empty && ((state_q == StIdle) || ((state_q == StStop) && baud_last));
    push_ok   = char_valid && (!fifo_full || pop);
    drop      = char_valid && !push_ok;
  end

  char_fifo #(
    .Width (8),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push_ok),
    .wdata_i (char_in),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Frame sequencer with baud counter; tx/busy registered from current state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      busy_q <= push_ok || !fifo_empty || (state_q != StIdle);
      unique case (state_q)
        StIdle: begin
          tx_q   <= 1'b1;
          baud_q <= '0;
          if (pop) begin
            shreg_q <= fifo_rdata;
`ifdef UART_TX_PARITY_EN
            par_q   <= ^fifo_rdata;
`endif
            state_q <= StStart;
          end
        end
        StStart: begin
          tx_q <= 1'b0;
          if (baud_last) begin
            baud_q    <= '0;
            bit_idx_q <= '0;
            state_q   <= StData;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        StData: begin
          tx_q <= shreg_q[0];
          if (baud_last) begin
            baud_q  <= '0;
            shreg_q <= {1'b0, shreg_q[7:1]};
            if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_q <= StParity;
`else
              state_q <= StStop;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        StParity: begin
          tx_q <= par_q;
          if (baud_last) begin
            baud_q  <= '0;
            state_q <= StStop;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
`endif
        StStop: begin
          tx_q <= 1'b1;
          if (baud_last) begin
            baud_q <= '0;
            if (pop) begin
              // Back-to-back frame: no idle gap.
              shreg_q <= fifo_rdata;
`ifdef UART_TX_PARITY_EN
              par_q   <= ^fifo_rdata;
`endif
              state_q <= StStart;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          baud_q  <= '0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Sticky overflow and saturating drop counter; a drop beats a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (ovf_clr)                  drop_cnt_q <= 8'd1;
      else if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 1'b1;
    end else if (ovf_clr) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_uart_char_tx.sv
// Self-checking bench for uart_char_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// A queue-based line model predicts every output each cycle; directed
// sequences decode the line at mid-bit and compare against hand-written frames.
module tb_uart_char_tx;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    char_in = '0;
  logic          char_valid = 1'b0;
  logic          ovf_clr = 1'b0;
  logic          tx, busy, fifo_full, overflow;
  logic [CW-1:0] fifo_count;
  logic [7:0]    drop_cnt;

  always #5 clk = ~clk;

  uart_char_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .char_in    (char_in),
    .char_valid (char_valid),
    .ovf_clr    (ovf_clr),
    .tx         (tx),
    .busy       (busy),
    .fifo_full  (fifo_full),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Line model: queued characters plus the tx values still to appear on the line.
  logic [7:0] mq[$];
  logic       mline[$];
  logic       e_tx, e_busy, m_ovf;
  logic [7:0] m_drop;

  // Directed vectors: byte, line order start..stop (MSB first), even parity.
  typedef struct {
    logic [7:0] data;
    logic [9:0] pattern;
    logic       par;
  } vec_t;
  vec_t vecs[6];

  task automatic append_frame(input logic [7:0] b);
    for (int i = 0; i < CPB; i++) mline.push_back(1'b0);
    for (int j = 0; j < 8; j++) for (int i = 0; i < CPB; i++) mline.push_back(b[j]);
`ifdef UART_TX_PARITY_EN
    for (int i = 0; i < CPB; i++) mline.push_back(^b);
`endif
    for (int i = 0; i < CPB; i++) mline.push_back(1'b1);
  endtask

  task automatic model_step(input logic cv, input logic [7:0] d, input logic clr, input logic r);
    logic pop, acc, from_frame;
    if (r) begin
      mq.delete();
      mline.delete();
      m_ovf  = 1'b0;
      m_drop = '0;
      e_tx   = 1'b1;
      e_busy = 1'b0;
      return;
    end
    // Next character may start once at most one line cycle of the current frame remains.
    pop = (mq.size() > 0) && (mline.size() <= 1);
    acc = cv && ((mq.size() < int'(DEPTH)) || pop);
    if (mline.size() > 0) begin
      e_tx = mline.pop_front();
      from_frame = 1'b1;
    end else begin
      e_tx = 1'b1;
      from_frame = 1'b0;
    end
    if (pop) append_frame(mq.pop_front());
    if (acc) mq.push_back(d);
    if (cv && !acc) begin
      m_ovf  = 1'b1;
      m_drop = clr ? 8'd1 : ((m_drop == 8'hFF) ? 8'hFF : m_drop + 8'd1);
    end else if (clr) begin
      m_ovf  = 1'b0;
      m_drop = '0;
    end
    e_busy = (mq.size() > 0) || from_frame || (mline.size() > 0);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance model, sample #1 after the edge, compare all outputs.
  task automatic cycle(input logic cv, input logic [7:0] d, input logic clr, input logic r);
    logic [CW-1:0] e_cnt;
    logic          e_full;
    char_valid = cv;
    char_in    = d;
    ovf_clr    = clr;
    rst        = r;
    model_step(cv, d, clr, r);
    @(posedge clk);
    #1;
    char_valid = 1'b0;
    ovf_clr    = 1'b0;
    rst        = 1'b0;
    e_cnt  = CW'(mq.size());
    e_full = (mq.size() == int'(DEPTH));
    checks++;
    if (tx !== e_tx || busy !== e_busy || fifo_full !== e_full || fifo_count !== e_cnt ||
        overflow !== m_ovf || drop_cnt !== m_drop) begin
      errors++;
      $display("FAIL model t=%0t tx=%b/%b busy=%b/%b full=%b/%b count=%0d/%0d ovf=%b/%b drop=%0d/%0d (actual/required)",
               $time, tx, e_tx, busy, e_busy, fifo_full, e_full, fifo_count, e_cnt,
               overflow, m_ovf, drop_cnt, m_drop);
    end
  endtask

  function automatic logic [10:0] exp_bits(input vec_t v);
    logic [10:0] r;
    r = '1;
    for (int i = 0; i < 10; i++) r[i] = v.pattern[9-i];
`ifdef UART_TX_PARITY_EN
    r[9]  = v.par;
    r[10] = 1'b1;
`endif
    return r;
  endfunction

  initial begin
    logic [10:0] obs0, obs1;
    int          busy_n, maxc, lows, thr;

    vecs[0] = '{8'h41, 10'b0100000101, 1'b0};
    vecs[1] = '{8'h55, 10'b0101010101, 1'b0};
    vecs[2] = '{8'hAA, 10'b0010101011, 1'b0};
    vecs[3] = '{8'h07, 10'b0111000001, 1'b1};
    vecs[4] = '{8'h00, 10'b0000000001, 1'b0};
    vecs[5] = '{8'hFF, 10'b0111111111, 1'b0};

    // Reset state.
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    chk("reset_tx", int'(tx), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_count", int'(fifo_count), 0);
    chk("reset_ovf", int'(overflow), 0);
    chk("reset_drop", int'(drop_cnt), 0);

    // Single frames from the vector table.
    for (int v = 0; v < 6; v++) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      cycle(1'b1, vecs[v].data, 1'b0, 1'b0);
      busy_n = int'(busy);
      obs0   = '1;
      for (int k = 1; k <= FRAME + 4; k++) begin
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        if (v == 0 && k == 1) chk("latency_tx_e1", int'(tx), 1);
        if (v == 0 && k == 2) chk("latency_tx_e2", int'(tx), 0);
        if (busy) busy_n++;
        if (k >= 2 && (k - 2) < FRAME && ((k - 2) % CPB) == 1) obs0[(k-2)/CPB] = tx;
      end
      chk($sformatf("frame_bits_%02h", vecs[v].data), int'(obs0), int'(exp_bits(vecs[v])));
      chk($sformatf("busy_len_%02h", vecs[v].data), busy_n, FRAME + 2);
    end

    // Back-to-back frames with no idle gap.
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b1, 8'h55, 1'b0, 1'b0);
    maxc = int'(fifo_count);
    cycle(1'b1, 8'hAA, 1'b0, 1'b0);
    if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
    obs0 = '1;
    obs1 = '1;
    for (int k = 2; k <= 2 * FRAME + 4; k++) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
      if ((k - 2) < 2 * FRAME && ((k - 2) % CPB) == 1) begin
        if ((k - 2) / CPB < NBITS) obs0[(k-2)/CPB] = tx;
        else                       obs1[(k-2)/CPB - NBITS] = tx;
      end
    end
    chk("b2b_frame0", int'(obs0), int'(exp_bits(vecs[1])));
    chk("b2b_frame1", int'(obs1), int'(exp_bits(vecs[2])));
    chk("b2b_max_count", maxc, 1);

    // Overflow: six consecutive pushes, sixth dropped; then clear; then drop+clear.
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
    chk("ovf_set", int'(overflow), 1);
    chk("ovf_drop1", int'(drop_cnt), 1);
    chk("ovf_full", int'(fifo_full), 1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("ovf_clr_flag", int'(overflow), 0);
    chk("ovf_clr_cnt", int'(drop_cnt), 0);
    cycle(1'b1, 8'h60, 1'b0, 1'b0);
    cycle(1'b1, 8'h61, 1'b1, 1'b0);
    chk("drop_beats_clr_flag", int'(overflow), 1);
    chk("drop_beats_clr_cnt", int'(drop_cnt), 1);
    for (int k = 0; k < 5 * FRAME + 10; k++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    chk("drained_count", int'(fifo_count), 0);
    chk("drained_busy", int'(busy), 0);

    // Reset mid-frame: line released, FIFO flushed, nothing further sent.
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b1, 8'h41, 1'b0, 1'b0);
    cycle(1'b1, 8'h42, 1'b0, 1'b0);
    for (int k = 2; k <= 15; k++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    chk("midrst_tx", int'(tx), 1);
    chk("midrst_count", int'(fifo_count), 0);
    chk("midrst_busy", int'(busy), 0);
    lows = 0;
    for (int k = 0; k < FRAME + 5; k++) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      if (!tx) lows++;
    end
    chk("midrst_quiet", lows, 0);

    // Full FIFO: push on the last stop cycle coincides with a pop and is kept.
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'h70 + 8'(i), 1'b0, 1'b0);
    chk("full_before", int'(fifo_count), 4);
    for (int k = 5; k <= FRAME; k++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b1, 8'h7F, 1'b0, 1'b0);
    chk("pushpop_count", int'(fifo_count), 4);
    chk("pushpop_ovf", int'(overflow), 0);
    cycle(1'b1, 8'h80, 1'b0, 1'b0);
    chk("full_nopop_drop", int'(overflow), 1);

    // Randomised traffic against the line model.
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int blk = 0; blk < 6; blk++) begin
      thr = (blk % 3 == 0) ? 3 : ((blk % 3 == 1) ? 12 : 70);
      for (int k = 0; k < 500; k++) begin
        cycle(($urandom_range(0, 99) < thr), 8'($urandom), ($urandom_range(0, 63) == 0),
              ($urandom_range(0, 999) == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
